// File: rtl/out_pack_pkg.sv
// Shared select codes, int8 range limits and lane index type for the output packing stage.
package out_pack_pkg;

    localparam logic [1:0] CFG_OFFSET  = 2'd0;
    localparam logic [1:0] CFG_ACT_MIN = 2'd1;
    localparam logic [1:0] CFG_ACT_MAX = 2'd2;

    localparam logic signed [7:0] INT8_MIN = 8'sh80;
    localparam logic signed [7:0] INT8_MAX = 8'sh7F;

    typedef logic [1:0] lane_idx_t;

endpackage

// File: rtl/out_pack_fifo.sv
// Two-entry synchronous FIFO; the head entry is held in a register so readers see registered data.
module out_pack_fifo #(
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    // Entries shift from tail to head on a pop; a push lands in the first free slot after that shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= push_data;
                    else                 tail_q <= push_data;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= push_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data = head_q;
    assign count     = count_q;

endmodule

// File: rtl/out_pack.sv
// Offsets, clamps and packs signed results into little-endian int8 words buffered in a 2-entry FIFO.
// Optional saturation counter: define OUT_PACK_SAT_CNT_EN to add the sat_count port.
module out_pack
    import out_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_sel,
    input  logic [31:0] cfg_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_bytes
`ifdef OUT_PACK_SAT_CNT_EN
    ,
    output logic [15:0] sat_count
`endif
);

    localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

    logic [31:0]        offset_q;
    logic signed [7:0]  act_min_q;
    logic signed [7:0]  act_max_q;
    lane_idx_t          idx_q;
    logic [3:0][7:0]    lanes_q;
    logic [3:0][7:0]    word_next;

    logic signed [32:0] s_val;
    logic signed [32:0] min_ext;
    logic signed [32:0] max_ext;
    logic               below;
    logic               above;
    logic               inverted;
    logic [7:0]         lane_byte;
    logic               accept;
    logic               commit;
    logic [34:0]        push_entry;
    logic [34:0]        head_entry;
    logic [1:0]         fifo_count;

    assign s_val    = $signed({in_data[31], in_data}) + $signed({offset_q[31], offset_q});
    assign min_ext  = $signed({{25{act_min_q[7]}}, act_min_q});
    assign max_ext  = $signed({{25{act_max_q[7]}}, act_max_q});
    assign below    = s_val < min_ext;
    assign above    = s_val > max_ext;
    assign inverted = act_min_q > act_max_q;

    // max-then-min clamp: an inverted range always collapses to act_max.
    always_comb begin
        lane_byte = s_val[7:0];
        if (inverted || above) lane_byte = act_max_q;
        else if (below)        lane_byte = act_min_q;
    end

    assign accept = in_valid && in_ready;
    assign commit = accept && ((idx_q == 2'd3) || in_last);

    always_comb begin
        word_next        = lanes_q;
        word_next[idx_q] = lane_byte;
    end

    assign push_entry = {word_next, {1'b0, idx_q} + 3'd1};

    always_ff @(posedge clk) begin
        if (reset) begin
            offset_q  <= '0;
            act_min_q <= INT8_MIN;
            act_max_q <= INT8_MAX;
        end else if (cfg_we) begin
            case (cfg_sel)
                CFG_OFFSET:  offset_q  <= cfg_data;
                CFG_ACT_MIN: act_min_q <= cfg_data[7:0];
                CFG_ACT_MAX: act_max_q <= cfg_data[7:0];
                default: ;
            endcase
        end
    end

    // Lanes are cleared on commit so a short (in_last) word leaves its upper bytes zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else if (accept) begin
            if (commit) begin
                idx_q   <= '0;
                lanes_q <= '0;
            end else begin
                idx_q   <= idx_q + 2'd1;
                lanes_q <= word_next;
            end
        end
    end

`ifdef OUT_PACK_SAT_CNT_EN
    logic [15:0] sat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= '0;
        end else if (cfg_we && (cfg_sel == CFG_OFFSET)) begin
            sat_q <= '0;
        end else if (accept && (below || above) && (sat_q != 16'hFFFF)) begin
            sat_q <= sat_q + 16'd1;
        end
    end

    assign sat_count = sat_q;
`endif

    out_pack_fifo #(
        .WIDTH(35)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (commit),
        .pop      (out_valid && out_ready),
        .push_data(push_entry),
        .head_data(head_entry),
        .count    (fifo_count)
    );

    assign in_ready  = fifo_count != FULL_COUNT;
    assign out_valid = fifo_count != 2'd0;
    assign out_data  = head_entry[34:3];
    assign out_bytes = head_entry[2:0];

endmodule
